// File: rtl/pcs25g_tx_am_dist.sv
// PCS25G transmit path: x^58+x^39+1 payload scrambler, per-lane alignment marker insertion
// and round-robin distribution over 4 PCS lanes. Define PCS25G_TX_ERRINJ_EN for inj_mode error injection.
module pcs25g_tx_am_dist #(
  parameter int unsigned AM_INTERVAL = 16383,
  parameter logic [57:0] SCR_SEED    = 58'h3FFFFFFFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [65:0] in_block,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [65:0] out_block,
  output logic [1:0]  out_lane,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [1:0]  inj_mode
);
  localparam int CNT_W = $clog2(AM_INTERVAL + 1);

  typedef enum logic {ST_AM, ST_DATA} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_lane_ptr;
  logic [CNT_W-1:0] r_round_cnt, w_round_inc;
  logic [7:0]       r_bip [4];
  logic [57:0]      r_scr, w_scr_nxt;
  logic [63:0]      w_scr_pay;
  logic [65:0]      r_out_block, w_am_blk, w_am_raw;
  logic [1:0]       r_out_lane, w_sync;
  logic             r_out_valid, w_adv, w_fire_am, w_fire_data, w_last_lane;

  // payload byte k sits at payload[8k+7:8k]: {M0,M1,M2,BIP3,M4,M5,M6,BIP7}
  function automatic logic [65:0] am_block(input logic [1:0] lane, input logic [7:0] bip);
    logic [47:0] m;
    case (lane)
      2'd0:    m = 48'hC16821_3E97DE;
      2'd1:    m = 48'h9D718E_628E71;
      2'd2:    m = 48'h594BE8_A6B417;
      default: m = 48'h4D957B_B26A84;
    endcase
    return {~bip, m[7:0], m[15:8], m[23:16], bip, m[31:24], m[39:32], m[47:40], 2'b01};
  endfunction

  function automatic logic [7:0] fold8(input logic [63:0] p);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) x = x ^ p[8*k +: 8];
    return x;
  endfunction

  assign w_adv       = ~r_out_valid | out_ready;
  assign in_ready    = w_adv & (r_state == ST_DATA);
  assign w_last_lane = (r_lane_ptr == 2'd3);
  assign w_round_inc = r_round_cnt + 1'b1;
  assign w_am_raw    = am_block(r_lane_ptr, r_bip[r_lane_ptr]);

  // Scrambler consumes payload LSB first; header bits bypass it.
  always_comb begin
    w_scr_nxt = r_scr;
    w_scr_pay = '0;
    for (int i = 0; i < 64; i++) begin
      w_scr_pay[i] = in_block[i+2] ^ w_scr_nxt[38] ^ w_scr_nxt[57];
      w_scr_nxt    = {w_scr_nxt[56:0], w_scr_pay[i]};
    end
  end

`ifdef PCS25G_TX_ERRINJ_EN
  logic r_inj_sync, r_inj_bip, w_inj_sync, w_inj_bip;

  assign w_inj_sync = r_inj_sync | inj_mode[0];
  assign w_inj_bip  = r_inj_bip | inj_mode[1];
  assign w_sync     = w_inj_sync ? 2'b11 : in_block[1:0];
  // only BIP3 bit0 (block bit 26) flips; BIP7 keeps the true value
  assign w_am_blk   = w_am_raw ^ (66'(w_inj_bip) << 26);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inj_sync <= 1'b0;
      r_inj_bip  <= 1'b0;
    end else begin
      r_inj_sync <= w_inj_sync & ~w_fire_data;
      r_inj_bip  <= w_inj_bip & ~w_fire_am;
    end
  end
`else
  logic w_unused_inj;

  assign w_unused_inj = ^inj_mode;
  assign w_sync       = in_block[1:0];
  assign w_am_blk     = w_am_raw;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fire_am   = 1'b0;
    w_fire_data = 1'b0;
    case (r_state)
      ST_AM: begin
        if (w_adv) begin
          w_fire_am = 1'b1;
          if (w_last_lane) w_state_nxt = ST_DATA;
        end
      end
      default: begin
        if (in_valid && in_ready) begin
          w_fire_data = 1'b1;
          if (w_last_lane && (w_round_inc == CNT_W'(AM_INTERVAL))) w_state_nxt = ST_AM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_AM;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_block <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      r_lane_ptr  <= '0;
      r_round_cnt <= '0;
      r_scr       <= SCR_SEED;
      for (int l = 0; l < 4; l++) r_bip[l] <= '0;
    end else if (w_fire_am) begin
      r_out_block         <= w_am_blk;
      r_out_lane          <= r_lane_ptr;
      r_out_valid         <= 1'b1;
      r_bip[r_lane_ptr]   <= '0;
      r_lane_ptr          <= r_lane_ptr + 2'd1;
      if (w_last_lane) r_round_cnt <= '0;
    end else if (w_fire_data) begin
      r_out_block         <= {w_scr_pay, w_sync};
      r_out_lane          <= r_lane_ptr;
      r_out_valid         <= 1'b1;
      r_bip[r_lane_ptr]   <= r_bip[r_lane_ptr] ^ fold8(w_scr_pay);
      r_scr               <= w_scr_nxt;
      r_lane_ptr          <= r_lane_ptr + 2'd1;
      if (w_last_lane) r_round_cnt <= w_round_inc;
    end else if (w_adv) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_block = r_out_block;
  assign out_lane  = r_out_lane;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pcs25g_tx_am_dist.sv
// Directed/randomised bench for pcs25g_tx_am_dist: reference scrambler/AM model, descrambler and hold checks.
// Error-injection checks are active when PCS25G_TX_ERRINJ_EN is defined.
module tb_pcs25g_tx_am_dist;
  localparam logic [57:0] SEED     = 58'h3FFFFFFFFFFFFFF;
  localparam int          AM_INT   = 2;
  localparam logic [65:0] SEED_BLK = {64'h03FFFF8000000000, 2'b10};

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [65:0] in_block, out_block;
  logic [1:0]  out_lane, inj_mode;
  logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [65:0] in_block1, out_block1;
  logic [1:0]  out_lane1;

  always #5 clk = ~clk;

  pcs25g_tx_am_dist #(.AM_INTERVAL(AM_INT), .SCR_SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .in_block(in_block), .in_valid(in_valid), .in_ready(in_ready),
    .out_block(out_block), .out_lane(out_lane), .out_valid(out_valid), .out_ready(out_ready),
    .inj_mode(inj_mode));

  pcs25g_tx_am_dist #(.AM_INTERVAL(1), .SCR_SEED(SEED)) u_dut1 (
    .clk(clk), .rst(rst1), .in_block(in_block1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_block(out_block1), .out_lane(out_lane1), .out_valid(out_valid1), .out_ready(out_ready1),
    .inj_mode(2'b00));

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [65:0] ref_am(input logic [1:0] lane, input logic [7:0] b3, input logic [7:0] b7);
    logic [47:0] mk;
    logic [7:0]  by [8];
    logic [63:0] p;
    case (lane)
      2'd0:    mk = 48'hC1_68_21_3E_97_DE;
      2'd1:    mk = 48'h9D_71_8E_62_8E_71;
      2'd2:    mk = 48'h59_4B_E8_A6_B4_17;
      default: mk = 48'h4D_95_7B_B2_6A_84;
    endcase
    by[0] = mk[47:40]; by[1] = mk[39:32]; by[2] = mk[31:24]; by[3] = b3;
    by[4] = mk[23:16]; by[5] = mk[15:8];  by[6] = mk[7:0];   by[7] = b7;
    for (int k = 0; k < 8; k++) p[8*k +: 8] = by[k];
    return {p, 2'b01};
  endfunction

  function automatic logic [63:0] scr64(input logic [63:0] p, input logic [57:0] s_in, output logic [57:0] s_out);
    logic [63:0] o;
    logic [57:0] s;
    s = s_in;
    for (int i = 0; i < 64; i++) begin
      o[i] = p[i] ^ s[38] ^ s[57];
      s    = {s[56:0], o[i]};
    end
    s_out = s;
    return o;
  endfunction

  function automatic logic [63:0] descr64(input logic [63:0] r, input logic [57:0] d_in, output logic [57:0] d_out);
    logic [63:0] o;
    logic [57:0] d;
    d = d_in;
    for (int i = 0; i < 64; i++) begin
      o[i] = r[i] ^ d[38] ^ d[57];
      d    = {d[56:0], r[i]};
    end
    d_out = d;
    return o;
  endfunction

  // reference model state, advanced on every observed handshake
  logic [65:0] q_in [$];
  logic        m_data, hold_v, m_inj_s, m_inj_b, e_s, e_b;
  logic [1:0]  m_lane;
  logic [7:0]  m_bip [4];
  logic [57:0] m_scr, d_scr;
  logic [63:0] pay, dpay;
  logic [65:0] blk, exp_blk, first_data;
  logic [67:0] hold_val;
  int          m_round, n_acc = 0, n_am_total = 0, n_am0 = 0, n_data_rst = 0, n_sync11 = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_data = 1'b0; m_lane = 2'd0; m_round = 0; m_scr = SEED; d_scr = SEED;
      for (int l = 0; l < 4; l++) m_bip[l] = 8'h00;
      q_in.delete(); hold_v = 1'b0; n_data_rst = 0; m_inj_s = 1'b0; m_inj_b = 1'b0;
    end else begin
      if (hold_v) check_eq("hold_stable", {out_lane, out_block}, hold_val);
      hold_v   = out_valid && !out_ready;
      hold_val = {out_lane, out_block};
      if (in_valid && in_ready) begin q_in.push_back(in_block); n_acc++; end
`ifdef PCS25G_TX_ERRINJ_EN
      e_s = m_inj_s | inj_mode[0];
      e_b = m_inj_b | inj_mode[1];
`else
      e_s = 1'b0;
      e_b = 1'b0;
`endif
      if (out_valid && out_ready) begin
        check_eq("lane", 68'(out_lane), 68'(m_lane));
        if (!m_data) begin
          check_eq("am", 68'(out_block), 68'(ref_am(m_lane, m_bip[m_lane] ^ {7'd0, e_b}, ~m_bip[m_lane])));
          e_b = 1'b0;
          m_bip[m_lane] = 8'h00;
          n_am_total++;
          if (m_lane == 2'd0) n_am0++;
          if (m_lane == 2'd3) begin m_data = 1'b1; m_round = 0; end
          m_lane = m_lane + 2'd1;
        end else if (q_in.size() == 0) begin
          check_eq("no_dup", 68'(q_in.size()), 68'd1);
        end else begin
          blk = q_in.pop_front();
          pay = scr64(blk[65:2], m_scr, m_scr);
          exp_blk = {pay, (e_s ? 2'b11 : blk[1:0])};
          e_s = 1'b0;
          check_eq("data", 68'(out_block), 68'(exp_blk));
          dpay = descr64(out_block[65:2], d_scr, d_scr);
          check_eq("descr", 68'(dpay), 68'(blk[65:2]));
          for (int k = 0; k < 8; k++) m_bip[m_lane] = m_bip[m_lane] ^ pay[8*k +: 8];
          if (n_data_rst == 0) first_data = out_block;
          n_data_rst++;
          if (out_block[1:0] == 2'b11) n_sync11++;
          if (m_lane == 2'd3) begin
            m_round++;
            if (m_round == AM_INT) m_data = 1'b0;
          end
          m_lane = m_lane + 2'd1;
        end
      end
      m_inj_s = e_s;
      m_inj_b = e_b;
    end
  end

  task automatic run_traffic(input int n_blk, input int pv, input int pr, input bit rnd);
    int target, snap, cyc;
    target = n_acc + n_blk; snap = n_acc; cyc = 0;
    in_valid = 1'b0;
    while (n_acc < target && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      if (in_valid && n_acc != snap) in_valid = 1'b0;
      if (n_acc < target && !in_valid && $urandom_range(99) < pv) begin
        in_block = rnd ? {$urandom(), $urandom(), ($urandom_range(1) == 1 ? 2'b01 : 2'b10)} : {64'h0, 2'b10};
        in_valid = 1'b1;
        snap     = n_acc;
      end
      out_ready = ($urandom_range(99) < pr);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("traffic_accepted", 68'(n_acc), 68'(target));
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [65:0] am_init [4];
  int          snap_i;

  initial begin
    am_init[0] = {64'hFFDE973E002168C1, 2'b01};
    am_init[1] = {64'hFF718E62008E719D, 2'b01};
    am_init[2] = {64'hFF17B4A600E84B59, 2'b01};
    am_init[3] = {64'hFF846AB2007B954D, 2'b01};
    rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b1; inj_mode = 2'b00;
    rst1 = 1'b1; in_valid1 = 1'b0; in_block1 = {64'h0, 2'b10}; out_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 68'(out_valid), 68'd0);
    check_eq("rst_out_block", 68'(out_block), 68'd0);
    check_eq("rst_out_lane", 68'(out_lane), 68'd0);
    check_eq("rst_in_ready", 68'(in_ready), 68'd0);

    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq("am_init_in_ready", 68'(in_ready), 68'd0);
      @(negedge clk);
      check_eq("am_init_block", 68'(out_block), 68'(am_init[k]));
      check_eq("am_init_lane", 68'(out_lane), 68'(k));
    end

    run_traffic(8, 100, 100, 1'b0);
    drain(10);
    check_eq("first_data_seed", 68'(first_data), 68'(SEED_BLK));
    check_eq("am_count_two_groups", 68'(n_am_total), 68'd8);

`ifndef PCS25G_TX_ERRINJ_EN
    inj_mode = 2'b11;
`endif
    run_traffic(1000, 70, 50, 1'b1);
    drain(20);
    inj_mode = 2'b00;
    check_eq("no_drop", 68'(q_in.size()), 68'd0);

    snap_i = n_am0;
    in_block = {64'h0, 2'b10};
    in_valid = 1'b1;
    for (int c = 0; c < 200 && n_am0 == snap_i; c++) begin
      @(posedge clk); #1;
    end
    check_eq("am0_seen", 68'(n_am0 - snap_i), 68'd1);
    check_eq("pre_rst_lane", 68'(out_lane), 68'd1);
    check_eq("pre_rst_sync", 68'(out_block[1:0]), 68'(2'b01));
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_out_valid", 68'(out_valid), 68'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_am0", 68'(out_block), 68'(am_init[0]));
    run_traffic(4, 100, 100, 1'b0);
    drain(10);
    check_eq("post_rst_seed", 68'(first_data), 68'(SEED_BLK));

`ifdef PCS25G_TX_ERRINJ_EN
    snap_i = n_sync11;
    @(posedge clk); #1; inj_mode = 2'b01;
    @(posedge clk); #1; inj_mode = 2'b00;
    run_traffic(8, 100, 100, 1'b0);
    drain(10);
    check_eq("inj_sync_once", 68'(n_sync11 - snap_i), 68'd1);
    @(posedge clk); #1; inj_mode = 2'b10;
    @(posedge clk); #1; inj_mode = 2'b00;
    run_traffic(8, 100, 100, 1'b0);
    drain(10);
`endif

    @(posedge clk); #1;
    rst1 = 1'b0; in_valid1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check_eq("int1_sync", 68'(out_block1[1:0]), 68'(((k / 4) % 2 == 0) ? 2'b01 : 2'b10));
      check_eq("int1_lane", 68'(out_lane1), 68'(k % 4));
      check_eq("int1_in_ready", 68'(in_ready1), 68'(((k % 8) >= 3 && (k % 8) <= 6) ? 1 : 0));
      if (k == 4) check_eq("int1_first_data", 68'(out_block1), 68'(SEED_BLK));
    end
    check_eq("int1_valid", 68'(out_valid1), 68'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
